// File: rtl/uart_pkg.sv
// Shared constants for the FIFO-draining UART transmitter.
// Includes the state encoding, the default bit period and the idle line level.
package uart_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_START = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_STOP  = 3'd5;

    localparam int DEFAULT_CLKS_PER_BIT = 16;

    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO-side handshake and serial-line signals of the transmitter.
// The slave modport is the transmitter; the master modport is its environment.
interface fifo_uart_tx_if #(
    parameter int WIDTH = 8
);

    logic             enable;
    logic             fifo_empty;
    logic             fifo_rd;
    logic [WIDTH-1:0] fifo_data;
    logic             tx;
    logic             busy;
    logic             frame_done;

    modport master (
        output enable,
        output fifo_empty,
        output fifo_data,
        input  fifo_rd,
        input  tx,
        input  busy,
        input  frame_done
    );

    modport slave (
        input  enable,
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd,
        output tx,
        output busy,
        output frame_done
    );

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and ticks on the last count.
// It restarts at zero after a tick and whenever clear is asserted.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int               CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops one word per frame from an upstream synchronous FIFO.
// Each word is sent LSB first, framed by one start bit and one stop bit.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic           clk,
    input  logic           reset,
    fifo_uart_tx_if.slave  bus
);

    localparam int               BIT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             tx_q, tx_d;
    logic             rd_q, rd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             baud_clear;
    logic             baud_tick;

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (baud_clear),
        .tick  (baud_tick)
    );

    // Outputs are computed for the next state so tx and fifo_rd come straight from flops.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rd_d    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = LINE_IDLE;
                if (bus.enable && !bus.fifo_empty) begin
                    state_d = ST_FETCH;
                    rd_d    = 1'b1;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                shift_d = bus.fifo_data;
                bit_d   = '0;
                tx_d    = 1'b0;
                state_d = ST_START;
            end
            ST_START: begin
                if (baud_tick) begin
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (bit_q == LAST_BIT) begin
                        tx_d    = LINE_IDLE;
                        state_d = ST_STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_d[0];
                    end
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                tx_d    = LINE_IDLE;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Held clear outside the timed states so START always begins a full bit period.
    assign baud_clear = (state_q == ST_IDLE) || (state_q == ST_FETCH) ||
                        (state_q == ST_LOAD) || (state_d != state_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            tx_q    <= LINE_IDLE;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.fifo_rd    = rd_q;
    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx with a small behavioural FIFO upstream.
// A line monitor decodes frames and checks them against a scoreboard of expected frames.
module tb_fifo_uart_tx;
    import uart_pkg::*;

    localparam int W  = 8;
    localparam int C  = 4;
    localparam int FL = (W + 2) * C;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fifo_uart_tx_if #(.WIDTH(W)) bus ();

    fifo_uart_tx #(
        .WIDTH        (W),
        .CLKS_PER_BIT (C)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Upstream FIFO: registered data_out, shares reset with the transmitter.
    logic [W-1:0] mem [16];
    logic [4:0]   wp, rp;
    logic         wr_en = 1'b0;
    logic [W-1:0] wr_data = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wp            <= '0;
            rp            <= '0;
            bus.fifo_data <= '0;
        end else begin
            if (wr_en) begin
                mem[wp[3:0]] <= wr_data;
                wp           <= wp + 5'd1;
            end
            if (bus.fifo_rd && (wp != rp)) begin
                bus.fifo_data <= mem[rp[3:0]];
                rp            <= rp + 5'd1;
            end
        end
    end
    assign bus.fifo_empty = (wp == rp);

    logic [9:0] sb [$];

    // Line monitor, sampling on the falling edge.
    int         cyc = 0, frames = 0, rd_cnt = 0, done_cnt = 0, idle_viol = 0;
    int         last_end = 0, last_gap = 0, k = 0;
    logic       in_frame = 1'b0, stable = 1'b1, prev_rd = 1'b0;
    logic [9:0] got = '0;
    logic [9:0] want;

    always @(negedge clk) begin
        cyc++;
        if (bus.frame_done === 1'b1) done_cnt++;
        if (bus.fifo_rd === 1'b1) begin
            rd_cnt++;
            chk("rd_single_cycle", {31'd0, prev_rd}, 32'd0);
        end
        prev_rd = bus.fifo_rd;
        if (bus.tx !== 1'b1 || bus.busy !== 1'b0) idle_viol++;
        if (reset) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame && bus.tx === 1'b0) begin
                in_frame = 1'b1;
                k        = 0;
                stable   = 1'b1;
                got      = '0;
                last_gap = cyc - last_end;
            end
            if (in_frame) begin
                if (k < FL) begin
                    if (k % C == 0) got[k / C] = bus.tx;
                    else if (bus.tx !== got[k / C]) stable = 1'b0;
                    k++;
                end else begin
                    chk("frame_done_at_end", {31'd0, bus.frame_done}, 32'd1);
                    chk("busy_low_at_end", {31'd0, bus.busy}, 32'd0);
                    chk("bits_stable", {31'd0, stable}, 32'd1);
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_underrun frame=%0h with nothing expected", got);
                    end else begin
                        want = sb.pop_front();
                        chk("frame_bits", {22'd0, got}, {22'd0, want});
                    end
                    frames++;
                    last_end = cyc;
                    in_frame = 1'b0;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] d, input logic [9:0] fr);
        wr_en   = 1'b1;
        wr_data = d;
        sb.push_back(fr);
        step(1);
        wr_en = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frames < target && n < budget) begin
            step(1);
            n++;
        end
        chk("frame_timeout", {31'd0, frames >= target}, 32'd1);
    endtask

    task automatic wait_bit(input int min_k, input int budget);
        int n;
        n = 0;
        while (!(in_frame && k >= min_k) && n < budget) begin
            step(1);
            n++;
        end
        chk("reach_bit_timeout", {31'd0, (in_frame && k >= min_k)}, 32'd1);
    endtask

    typedef struct {
        logic [W-1:0] data;
        logic [9:0]   frame;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, r0, d0, v0;

        // {stop, data[7:0], start} as the line carries them, LSB first.
        vecs[0] = '{8'hA5, 10'b1_10100101_0};
        vecs[1] = '{8'h00, 10'b1_00000000_0};
        vecs[2] = '{8'hFF, 10'b1_11111111_0};
        vecs[3] = '{8'h3C, 10'b1_00111100_0};
        vecs[4] = '{8'h5A, 10'b1_01011010_0};
        vecs[5] = '{8'hC3, 10'b1_11000011_0};
        vecs[6] = '{8'h01, 10'b1_00000001_0};
        vecs[7] = '{8'h80, 10'b1_10000000_0};

        bus.enable = 1'b0;
        #1 reset = 1'b1;
        #2;
        chk("reset_tx", {31'd0, bus.tx}, {31'd0, LINE_IDLE});
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_rd", {31'd0, bus.fifo_rd}, 32'd0);
        chk("reset_done", {31'd0, bus.frame_done}, 32'd0);
        step(2);
        reset = 1'b0;
        step(1);

        // Empty FIFO with enable high: nothing happens.
        r0 = rd_cnt; v0 = idle_viol;
        bus.enable = 1'b1;
        step(100);
        chk("empty_no_rd", rd_cnt - r0, 0);
        chk("empty_line_idle", idle_viol - v0, 0);

        // Single frames from the vector table.
        for (int i = 0; i < 8; i++) begin
            f0 = frames; r0 = rd_cnt; d0 = done_cnt;
            push_word(vecs[i].data, vecs[i].frame);
            wait_frames(f0 + 1, 100);
            step(3);
            chk("vec_rd_count", rd_cnt - r0, 1);
            chk("vec_done_count", done_cnt - d0, 1);
            chk("vec_busy_idle", {31'd0, bus.busy}, 32'd0);
        end

        // Back-to-back 0x00 then 0xFF.
        bus.enable = 1'b0;
        f0 = frames; d0 = done_cnt;
        push_word(8'h00, 10'b1_00000000_0);
        push_word(8'hFF, 10'b1_11111111_0);
        bus.enable = 1'b1;
        wait_frames(f0 + 2, 200);
        step(2);
        chk("b2b_gap", last_gap, 3);
        chk("b2b_done_count", done_cnt - d0, 2);
        chk("b2b_busy", {31'd0, bus.busy}, 32'd0);
        chk("b2b_empty", {31'd0, bus.fifo_empty}, 32'd1);

        // Word waiting while enable is low.
        bus.enable = 1'b0;
        f0 = frames;
        push_word(8'h3C, 10'b1_00111100_0);
        r0 = rd_cnt; v0 = idle_viol;
        step(50);
        chk("disabled_no_rd", rd_cnt - r0, 0);
        chk("disabled_line_idle", idle_viol - v0, 0);
        bus.enable = 1'b1;
        @(negedge clk);
        chk("no_fetch_before_edge", {31'd0, bus.fifo_rd}, 32'd0);
        @(negedge clk);
        chk("fetch_first_edge", {31'd0, bus.fifo_rd}, 32'd1);
        wait_frames(f0 + 1, 100);

        // Enable dropped during DATA of the first of two queued words.
        bus.enable = 1'b0;
        step(1);
        f0 = frames; r0 = rd_cnt;
        push_word(8'hC3, 10'b1_11000011_0);
        push_word(8'h01, 10'b1_00000001_0);
        bus.enable = 1'b1;
        wait_bit(2 * C + 2, 100);
        bus.enable = 1'b0;
        wait_frames(f0 + 1, 100);
        step(30);
        chk("drop_en_frames", frames - f0, 1);
        chk("drop_en_rd", rd_cnt - r0, 1);
        chk("drop_en_not_empty", {31'd0, bus.fifo_empty}, 32'd0);
        bus.enable = 1'b1;
        wait_frames(f0 + 2, 100);
        step(2);
        chk("drain_empty", {31'd0, bus.fifo_empty}, 32'd1);

        // Reset during data bit 3 of 0x5A, then a clean frame.
        f0 = frames;
        push_word(8'h5A, 10'b1_01011010_0);
        wait_bit(4 * C + 2, 100);
        #6;
        reset = 1'b1;
        #1;
        chk("async_rst_tx", {31'd0, bus.tx}, 32'd1);
        chk("async_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("async_rst_rd", {31'd0, bus.fifo_rd}, 32'd0);
        sb.delete();
        step(2);
        reset = 1'b0;
        step(1);
        chk("aborted_not_counted", frames - f0, 0);
        push_word(8'h5A, 10'b1_01011010_0);
        wait_frames(f0 + 1, 100);
        step(2);
        chk("post_reset_sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
